adc_serial_engine: RTL and testbench

Serial front end for the on-board LTC2308-style 12-bit SPI ADC. It sits directly below the Avalon ADC wrapper: it takes the wrapper's `go` request, runs one burst that converts channels 0..NUM_CH over SPI, and returns all results at once with a `done` handshake. The wrapper latches the results on `done`.

---
 rtl/adc_serial_pkg.sv | 19 +
 rtl/adc_sclk_gen.sv | 41 ++++
 rtl/adc_serial_engine.sv | 136 +++++++++++++
 tb/tb_adc_serial_engine.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_serial_pkg.sv
// Shared types and helpers for the LTC2308-style serial ADC front end.
package adc_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CONV  = 2'd2,
        FIN   = 2'd3
    } adc_state_e;

    localparam int ADC_FRAME_BITS = 12;
    localparam int ADC_CFG_BITS   = 6;

    // Config word {S/D, O/S, S1, S0, UNI, SLP}: single-ended, unipolar, channel mux bits.
    function automatic logic [ADC_CFG_BITS-1:0] adc_cfg_word(input logic [2:0] ch, input logic slp);
        return {1'b1, ch[0], ch[2], ch[1], 1'b1, slp};
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK divider for the serial ADC frame: half-period of T_SCLK clocks while enabled,
// with one-cycle strobes that fire on the clock edge where the divided clock toggles.
module adc_sclk_gen #(
    parameter int T_SCLK = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    output logic       adc_sclk,
    output logic       rise_stb,
    output logic       fall_stb,
    output logic [3:0] bit_cnt
);

    logic [7:0] div_cnt;
    logic       tick;

    assign tick     = en && (div_cnt == 8'(T_SCLK - 1));
    assign rise_stb = tick && !adc_sclk;
    assign fall_stb = tick && adc_sclk;

    // bit_cnt counts completed SCLK periods within the frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            adc_sclk <= 1'b0;
            bit_cnt  <= '0;
        end else if (!en) begin
            div_cnt  <= '0;
            adc_sclk <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
            if (tick)
                adc_sclk <= !adc_sclk;
            if (fall_stb)
                bit_cnt <= bit_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/adc_serial_engine.sv
// Burst controller for an LTC2308-style SPI ADC: converts channels 0..NUM_CH per go request.
// Optional ADC_SERIAL_SLEEP_EN: dummy frame sets SLP=1 and each burst starts with a wake wait.
module adc_serial_engine
    import adc_serial_pkg::*;
#(
    parameter int T_SCLK = 6,
    parameter int NUM_CH = 7,
    parameter int T_CONV = 80
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        go,
    output logic        done,
    output logic [95:0] ch_data,
    output logic        adc_sclk,
    output logic        adc_cs_n,
    output logic        adc_din,
    input  logic        adc_dout
);

    localparam int CW = $clog2(T_CONV + 2);
    localparam logic [3:0]    LAST_F    = 4'(NUM_CH + 1);
    localparam logic [3:0]    TOP_CH    = 4'(NUM_CH);
    localparam logic [CW-1:0] CONV_LAST = CW'(T_CONV - 1);
    localparam logic [CW-1:0] WAKE_LAST = CW'(T_CONV);

    adc_state_e                state, next_state;
    logic [3:0]                frame;
    logic [CW-1:0]             conv_cnt;
    logic [ADC_FRAME_BITS-1:0] shift_reg;
    logic [ADC_FRAME_BITS-1:0] stage [8];
    logic                      waking, slp, conv_end, shift_end;
    logic                      sclk_pre, rise_stb, fall_stb;
    logic [3:0]                bit_cnt;
    logic [2:0]                cfg_ch, din_idx, stage_idx;
    logic [ADC_CFG_BITS-1:0]   cfg;
    logic                      cs_n_nxt, din_nxt;

    adc_sclk_gen #(.T_SCLK(T_SCLK)) u_sclk_gen (
        .clock    (clock),
        .reset_n  (reset_n),
        .en       (state == SHIFT),
        .adc_sclk (sclk_pre),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .bit_cnt  (bit_cnt)
    );

`ifdef ADC_SERIAL_SLEEP_EN
    localparam adc_state_e START_STATE = CONV;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            waking <= 1'b0;
        else if (state == IDLE && go && !done)
            waking <= 1'b1;
        else if (conv_end)
            waking <= 1'b0;
    end
    assign slp = (frame == LAST_F);
`else
    localparam adc_state_e START_STATE = SHIFT;
    assign waking = 1'b0;
    assign slp    = 1'b0;
`endif

    assign shift_end = fall_stb && (bit_cnt == 4'd11);
    assign conv_end  = (state == CONV) && (conv_cnt == (waking ? WAKE_LAST : CONV_LAST));
    assign stage_idx = frame[2:0] - 3'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (go && !done) next_state = START_STATE;
            SHIFT:   if (shift_end) next_state = CONV;
            CONV:    if (conv_end) next_state = (waking || frame != LAST_F) ? SHIFT : FIN;
            FIN:     if (!go) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pin values are computed from the current state and registered, so every pin lags the FSM by one clock.
    always_comb begin
        cfg_ch   = (frame <= TOP_CH) ? frame[2:0] : 3'd0;
        cfg      = adc_cfg_word(cfg_ch, slp);
        din_idx  = 3'd5 - bit_cnt[2:0];
        cs_n_nxt = !((state == SHIFT) || (state == CONV && waking && conv_cnt == '0));
        din_nxt  = (state == SHIFT && bit_cnt < 4'd6) ? cfg[din_idx] : 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            adc_sclk <= 1'b0;
            adc_cs_n <= 1'b1;
            adc_din  <= 1'b0;
        end else begin
            adc_sclk <= sclk_pre;
            adc_cs_n <= cs_n_nxt;
            adc_din  <= din_nxt;
        end
    end

    // Frame f returns the result of frame f-1's channel; frame 0's word is stale and dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame     <= '0;
            conv_cnt  <= '0;
            shift_reg <= '0;
            done      <= 1'b0;
            ch_data   <= '0;
            for (int i = 0; i < 8; i++)
                stage[i] <= '0;
        end else begin
            conv_cnt <= (state == CONV && !conv_end) ? conv_cnt + CW'(1) : '0;
            if (state == IDLE)
                frame <= '0;
            else if (conv_end && !waking && frame != LAST_F)
                frame <= frame + 4'd1;
            if (rise_stb)
                shift_reg <= {shift_reg[ADC_FRAME_BITS-2:0], adc_dout};
            if (shift_end && frame != 4'd0)
                stage[stage_idx] <= shift_reg;
            done <= (state == FIN);
            if (state == FIN && !done)
                for (int i = 0; i < 8; i++)
                    ch_data[i*ADC_FRAME_BITS +: ADC_FRAME_BITS] <= (i <= NUM_CH) ? stage[i] : '0;
        end
    end

endmodule

// File: tb/tb_adc_serial_engine.sv
// Directed bench for adc_serial_engine: default instance plus a NUM_CH=0, T_SCLK=2 instance,
// each driven by a small behavioural LTC2308-style ADC model.
module tb_adc_serial_engine;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        go_a = 1'b0;
    logic        go_b = 1'b0;
    logic        done_a, done_b;
    logic [95:0] ch_data_a, ch_data_b;
    logic        adc_sclk_a, adc_cs_n_a, adc_din_a;
    logic        adc_sclk_b, adc_cs_n_b, adc_din_b;
    logic        adc_dout_a = 1'b0;
    logic        adc_dout_b = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    adc_serial_engine u_dut_a (
        .clock    (clock),
        .reset_n  (reset_n),
        .go       (go_a),
        .done     (done_a),
        .ch_data  (ch_data_a),
        .adc_sclk (adc_sclk_a),
        .adc_cs_n (adc_cs_n_a),
        .adc_din  (adc_din_a),
        .adc_dout (adc_dout_a)
    );

    adc_serial_engine #(.T_SCLK(2), .NUM_CH(0), .T_CONV(80)) u_dut_b (
        .clock    (clock),
        .reset_n  (reset_n),
        .go       (go_b),
        .done     (done_b),
        .ch_data  (ch_data_b),
        .adc_sclk (adc_sclk_b),
        .adc_cs_n (adc_cs_n_b),
        .adc_din  (adc_din_b),
        .adc_dout (adc_dout_b)
    );

    // ADC model A: returns base+channel of the previous frame, logs config words and pulse shapes.
    logic [11:0] base_a = 12'h100;
    logic [2:0]  prev_ch_a = 3'd0;
    logic [11:0] out_a = '0;
    logic [5:0]  cfg_a = '0;
    logic        cs_q_a = 1'b1;
    logic        sclk_q_a = 1'b0;
    int          bits_a = 0, rises_a = 0, low_len_a = 0;
    int          pulse_cnt = 0, pulse_bad = 0, rise_bad = 0;
    logic [5:0]  cfg_log [$];

    always @(negedge clock) begin
        if (!reset_n) begin
            cs_q_a = 1'b1;
            sclk_q_a = 1'b0;
            adc_dout_a = 1'b0;
        end else begin
            if (cs_q_a && !adc_cs_n_a) begin
                out_a = base_a + 12'(prev_ch_a);
                adc_dout_a = out_a[11];
                bits_a = 1;
                rises_a = 0;
                low_len_a = 0;
                cfg_a = '0;
            end
            if (!adc_cs_n_a) low_len_a++;
            if (!cs_q_a && adc_cs_n_a) begin
                pulse_cnt++;
                if (low_len_a != 144) pulse_bad++;
                if (rises_a != 12) rise_bad++;
                prev_ch_a = {cfg_a[3], cfg_a[2], cfg_a[4]};
                cfg_log.push_back(cfg_a);
            end
            if (!adc_cs_n_a && !sclk_q_a && adc_sclk_a) begin
                rises_a++;
                if (rises_a <= 6) cfg_a = {cfg_a[4:0], adc_din_a};
            end
            if (!adc_cs_n_a && sclk_q_a && !adc_sclk_a && bits_a < 12) begin
                adc_dout_a = out_a[11 - bits_a];
                bits_a++;
            end
            cs_q_a = adc_cs_n_a;
            sclk_q_a = adc_sclk_a;
        end
    end

    // ADC model B: data path only.
    logic [11:0] base_b = 12'h155;
    logic [2:0]  prev_ch_b = 3'd0;
    logic [11:0] out_b = '0;
    logic [5:0]  cfg_b = '0;
    logic        cs_q_b = 1'b1;
    logic        sclk_q_b = 1'b0;
    int          bits_b = 0, rises_b = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            cs_q_b = 1'b1;
            sclk_q_b = 1'b0;
            adc_dout_b = 1'b0;
        end else begin
            if (cs_q_b && !adc_cs_n_b) begin
                out_b = base_b + 12'(prev_ch_b);
                adc_dout_b = out_b[11];
                bits_b = 1;
                rises_b = 0;
                cfg_b = '0;
            end
            if (!cs_q_b && adc_cs_n_b)
                prev_ch_b = {cfg_b[3], cfg_b[2], cfg_b[4]};
            if (!adc_cs_n_b && !sclk_q_b && adc_sclk_b) begin
                rises_b++;
                if (rises_b <= 6) cfg_b = {cfg_b[4:0], adc_din_b};
            end
            if (!adc_cs_n_b && sclk_q_b && !adc_sclk_b && bits_b < 12) begin
                adc_dout_b = out_b[11 - bits_b];
                bits_b++;
            end
            cs_q_b = adc_cs_n_b;
            sclk_q_b = adc_sclk_b;
        end
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_done(input bit sel_b, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((sel_b ? done_b : done_a) === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    function automatic logic [95:0] exp_data(input logic [11:0] base, input int top);
        logic [95:0] r;
        r = '0;
        for (int i = 0; i <= top; i++)
            r[i*12 +: 12] = base + 12'(i);
        return r;
    endfunction

    logic [5:0] cfg_tab [8] = '{6'b100010, 6'b110010, 6'b100110, 6'b110110,
                                6'b101010, 6'b111010, 6'b101110, 6'b111110};
    logic [5:0] exp_q [$];
    logic [5:0] got_cfg;
    int k, at, pulses, lows, cs_low, highs;

    initial begin
        repeat (5) step();
        check("rst_cs_n", adc_cs_n_a, 1'b1);
        check("rst_sclk", adc_sclk_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_ch_data", ch_data_a, '0);
        check("rst_din", adc_din_a, 1'b0);
        reset_n = 1'b1;
        repeat (3) step();

        // NUM_CH=0, T_SCLK=2: two frames
        base_b = 12'h155;
        go_b = 1'b1;
        k = cyc + 1;
        wait_done(1'b1, 600, at);
        check("b_latency", at, k + 257);
        check("b_ch0", ch_data_b[11:0], 12'h155);
        check("b_upper_zero", ch_data_b[95:12], '0);
        go_b = 1'b0;
        repeat (3) step();

        // Default burst, go held high
        pulse_cnt = 0; pulse_bad = 0; rise_bad = 0;
        cfg_log.delete();
        base_a = 12'h100;
        go_a = 1'b1;
        k = cyc + 1;
        wait_done(1'b0, 2500, at);
        check("a_latency", at, k + 2017);
        check("a_ch_data", ch_data_a, exp_data(12'h100, 7));
        check("a_pulse_count", pulse_cnt, 9);
        check("a_pulse_len_bad", pulse_bad, 0);
        check("a_sclk_rises_bad", rise_bad, 0);
        check("a_cfg_count", cfg_log.size(), 9);
        for (int f = 0; f < 9; f++)
            exp_q.push_back(cfg_tab[(f <= 7) ? f : 0]);
        for (int f = 0; f < 9; f++) begin
            got_cfg = (cfg_log.size() > 0) ? cfg_log.pop_front() : 6'h3f;
            check($sformatf("a_cfg_f%0d", f), got_cfg, exp_q.pop_front());
        end

        // go held: done stays, no new frame
        pulses = pulse_cnt; lows = 0; cs_low = 0;
        repeat (300) begin
            step();
            if (!done_a) lows++;
            if (!adc_cs_n_a) cs_low++;
        end
        check("hold_done_low_cycles", lows, 0);
        check("hold_cs_low_cycles", cs_low, 0);
        check("hold_no_new_frame", pulse_cnt, pulses);
        go_a = 1'b0;
        step();
        check("drop_done_edge_m", done_a, 1'b1);
        step();
        check("drop_done_m_plus_1", done_a, 1'b0);

        // Re-raised go starts a new burst; ch_data holds old values until FIN
        base_a = 12'h200;
        go_a = 1'b1;
        k = cyc + 1;
        repeat (1000) step();
        check("mid_ch_data_stable", ch_data_a, exp_data(12'h100, 7));
        check("mid_done_low", done_a, 1'b0);
        wait_done(1'b0, 1500, at);
        check("b2_latency", at, k + 2017);
        check("b2_ch_data", ch_data_a, exp_data(12'h200, 7));
        go_a = 1'b0;
        repeat (3) step();

        // One-cycle go pulse
        base_a = 12'h300;
        go_a = 1'b1;
        k = cyc + 1;
        step();
        go_a = 1'b0;
        wait_done(1'b0, 2500, at);
        check("pulse_latency", at, k + 2017);
        check("pulse_ch_data", ch_data_a, exp_data(12'h300, 7));
        highs = (at >= 0) ? 1 : 0;
        repeat (5) begin
            step();
            if (done_a) highs++;
        end
        check("pulse_done_width", highs, 1);

        // Reset during SHIFT of frame 0
        go_a = 1'b1;
        repeat (60) step();
        check("pre_reset_cs_low", adc_cs_n_a, 1'b0);
        reset_n = 1'b0;
        step();
        check("midrst_cs_n", adc_cs_n_a, 1'b1);
        check("midrst_sclk", adc_sclk_a, 1'b0);
        check("midrst_done", done_a, 1'b0);
        check("midrst_ch_data", ch_data_a, '0);
        check("midrst_din", adc_din_a, 1'b0);
        go_a = 1'b0;
        reset_n = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
